rhd_cmd_scheduler: RTL and testbench
====================================

# rhd_cmd_scheduler

Frame-level command sequencer for the RHD2000 SPI front end. Generates the 16-bit MOSI command stream for each sampling frame: one CONVERT per amplifier channel, followed by a fixed number of auxiliary slots. Auxiliary slots are filled from a software-loaded FIFO, or with a dummy ROM read when the FIFO is empty. Sits between the AXI-lite control registers (run, DSP enable, batch length) and the SPI shifter that drives CS/SCLK/MOSI1/MOSI2. Also counts frames and flags batch boundaries for the MISO packetiser.

## Interface
- NUM_CH, 32, CONVERT slots per frame (1..64)
- AUX_SLOTS, 3, auxiliary slots per frame (1..8)
- AUX_FIFO_DEPTH, 16, aux command FIFO entries (power of two, ≥2)
- aclk  in  1  system clock; all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- run  in  1  level; 1 = acquire, 0 = stop at end of current frame
- dsp_hpf  in  1  H bit placed in CONVERT words; sampled at frame start
- batch_len  in  16  frames per batch; 0 treated as 1; sampled at frame start
- aux_wr_valid  in  1  push request for aux FIFO
- aux_wr_data  in  16  aux command word
- aux_wr_ready  out  1  FIFO not full
- aux_level  out  $clog2(AUX_FIFO_DEPTH)+1  FIFO occupancy
- cmd_valid  out  1  command word available to SPI shifter
- cmd_data  out  16  command word
- cmd_ready  in  1  SPI shifter accepts word on edge where valid&&ready
- frame_start  out  1  one-cycle pulse with first word of each frame
- batch_done  out  1  one-cycle pulse after last word of a batch accepted
- busy  out  1  1 from run-start until stop completes
- frame_count  out  32  frames completed since last start, wraps at 2^32

## Operation
- Encodings: CONVERT(c) = {2'b00, c[5:0], 7'b0, dsp_hpf}; dummy = READ(40) = 16'hE800; CALIBRATE = 16'h5500.
- States: IDLE, CONV, AUX.
- IDLE: cmd_valid=0. Leave on run=1: load slot=0, snapshot dsp_hpf and batch_len, clear frame_count and batch counter, go to CONV.
- CONV: presents CONVERT(slot). On accept: slot<NUM_CH-1 → slot+1; else → AUX, aux index 0.
- AUX: presents FIFO head if FIFO non-empty at the accepting edge of the previous word, else 16'hE800. The FIFO pops on acceptance of a FIFO-sourced word only. On accept of aux index AUX_SLOTS-1: frame_count++, batch counter++.
  - If the batch counter reaches batch_len, pulse batch_done and reset the batch counter.
  - Then: run=1 → CONV slot 0 (new frame, re-snapshot dsp_hpf and batch_len); run=0 → IDLE.
- run deassert mid-frame has no effect until the frame finishes. Frames are never truncated.
- FIFO: push when aux_wr_valid&&aux_wr_ready. A push on the same edge as a pop is allowed when not full. When full, aux_wr_ready=0 and the push is ignored. A word pushed on the edge a slot is decided is not used for that slot.
- busy = (state != IDLE).

## Timing
- Reset values: cmd_valid=0, cmd_data=0, frame_start=0, batch_done=0, busy=0, frame_count=0, aux_level=0, aux_wr_ready=1, state IDLE, FIFO emptied.
- run sampled 1 in IDLE at edge N → cmd_valid=1, cmd_data=CONVERT(0), frame_start=1 in cycle N+1.
- Zero-bubble: on an accepting edge, cmd_data updates to the next word and cmd_valid stays 1. Minimum frame is NUM_CH+AUX_SLOTS cycles.
- cmd_data and cmd_valid are held stable while cmd_valid&&!cmd_ready.
- Final accept of a frame with run=0 → cmd_valid=0 and busy=0 the next cycle.
- batch_done and the frame_count increment are visible the cycle after the last aux word is accepted.
- aresetn assertion mid-frame clears all state immediately. No partial frame resumes after release.

## Configuration
- RHD_CMD_SCHED_CAL_EN defined: the first frame after each IDLE→CONV transition presents CALIBRATE (16'h5500) in aux slot 0, overriding the FIFO (no pop) and the dummy. Remaining slots and frames behave normally.
- Undefined: no automatic calibrate; aux slot 0 behaves like every other aux slot.

## Test plan
- Defaults, cmd_ready=1, run=1 for 2 frames then 0 → words CONVERT(0..31) with H=0, then 3× 16'hE800, repeated; 70 words total; frame_count=2; busy drops one cycle after word 70.
- Push 16'h8012 and 16'hC000 before start, run 1 frame → aux slots carry 16'h8012, 16'hC000, 16'hE800; aux_level ends at 0.
- batch_len=0 then batch_len=3, run 6 frames → batch_done pulses after every frame in the first case; after frames 3 and 6 in the second.
- cmd_ready random 30% duty → stream identical to the ready=1 case; cmd_data never changes while valid&&!ready.
- Fill FIFO to 16, push a 17th → aux_wr_ready=0, word dropped, aux_level=16; simultaneous push/pop at level 5 leaves level 5.
- Assert aresetn=0 at word 10 of a frame, release, run=1 → stream restarts at CONVERT(0), frame_count=0. With RHD_CMD_SCHED_CAL_EN, first aux word is 16'h5500.

Source files
------------

// File: rtl/rhd_cmd_scheduler.sv
// rtl/rhd_cmd_scheduler.sv - RHD2000 frame-level SPI command sequencer with aux command FIFO
//
// Purpose: emits the 16-bit MOSI command stream for each sampling frame.
//   One CONVERT per amplifier channel, then AUX_SLOTS auxiliary words. Each aux
//   word is the head of a software-loaded FIFO, or the dummy READ(40) when the
//   FIFO is empty. The block also counts frames and flags batch boundaries.
//
// Build option: RHD_CMD_SCHED_CAL_EN
//   When defined, aux slot 0 of the first frame after each start carries
//   CALIBRATE (16'h5500). That word overrides the FIFO and does not pop it.
//
// Ports:
//   aclk, aresetn         clock; asynchronous active-low reset
//   run                   level; 1 = acquire, 0 = stop at end of current frame
//   dsp_hpf               H bit for CONVERT words, sampled at frame start
//   batch_len             frames per batch (0 acts as 1), sampled at frame start
//   aux_wr_valid/data     aux FIFO push
//   aux_wr_ready          FIFO not full
//   aux_level             FIFO occupancy
//   cmd_valid/data/ready  command word handshake to the SPI shifter
//   frame_start           pulse, coincident with the first word of each frame
//   batch_done            pulse, the cycle after the last word of a batch is accepted
//   busy                  high while a run is in progress
//   frame_count           frames completed since the last start
module rhd_cmd_scheduler #(
  parameter int NUM_CH         = 32,
  parameter int AUX_SLOTS      = 3,
  parameter int AUX_FIFO_DEPTH = 16
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              run,
  input  logic                              dsp_hpf,
  input  logic [15:0]                       batch_len,
  input  logic                              aux_wr_valid,
  input  logic [15:0]                       aux_wr_data,
  output logic                              aux_wr_ready,
  output logic [$clog2(AUX_FIFO_DEPTH):0]   aux_level,
  output logic                              cmd_valid,
  output logic [15:0]                       cmd_data,
  input  logic                              cmd_ready,
  output logic                              frame_start,
  output logic                              batch_done,
  output logic                              busy,
  output logic [31:0]                       frame_count
);

  localparam int              PW         = $clog2(AUX_FIFO_DEPTH);
  localparam int              LW         = PW + 1;
  localparam logic [15:0]     DUMMY_WORD = 16'hE800;
  localparam logic [5:0]      LAST_CH    = 6'(NUM_CH - 1);
  localparam logic [2:0]      LAST_AUX   = 3'(AUX_SLOTS - 1);
  localparam logic [LW-1:0]   FIFO_FULL  = LW'(AUX_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_AUX} state_e;

  state_e       state_q, state_d;
  logic [5:0]   slot_q, slot_d;
  logic [2:0]   aux_idx_q, aux_idx_d;
  logic         hpf_q, hpf_d;
  logic [15:0]  batch_len_q, batch_len_d;
  logic [15:0]  batch_cnt_q, batch_cnt_d;
  logic [31:0]  frame_cnt_q, frame_cnt_d;
  logic         cmd_valid_q, cmd_valid_d;
  logic [15:0]  cmd_data_q, cmd_data_d;
  logic         frame_start_q, frame_start_d;
  logic         batch_done_q, batch_done_d;
  // The word currently presented was taken from the FIFO, so its acceptance pops.
  logic         aux_src_q, aux_src_d;

  logic [15:0]  fifo_mem [AUX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q;

  logic         accept, push, pop;
  logic         fifo_avail;
  logic [15:0]  fifo_next_head;
  logic [15:0]  aux_word;
  logic         aux_word_src;
  logic         cal_take;
  logic [15:0]  eff_len;

  function automatic logic [15:0] convert_word(input logic [5:0] ch, input logic h);
    return {2'b00, ch, 7'b0, h};
  endfunction

  assign accept = cmd_valid_q && cmd_ready;
  assign push   = aux_wr_valid && (count_q != FIFO_FULL);
  assign pop    = accept && aux_src_q;

  // The next aux slot is decided on the edge that accepts the previous word.
  // A pop on that same edge is taken into account, but a push on that edge is not.
  assign fifo_avail     = (count_q - LW'(pop)) != '0;
  assign fifo_next_head = fifo_mem[pop ? rd_ptr_q + PW'(1) : rd_ptr_q];

`ifdef RHD_CMD_SCHED_CAL_EN
  logic cal_pend_q, cal_pend_d;
  // Aux slot 0 is only ever entered from CONV.
  assign cal_take = cal_pend_q && (state_q == S_CONV);
`else
  assign cal_take = 1'b0;
`endif

  always_comb begin
    aux_word     = DUMMY_WORD;
    aux_word_src = 1'b0;
    if (cal_take) begin
      aux_word = 16'h5500;
    end else if (fifo_avail) begin
      aux_word     = fifo_next_head;
      aux_word_src = 1'b1;
    end
  end

  assign eff_len = (batch_len_q == 16'd0) ? 16'd1 : batch_len_q;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    aux_idx_d     = aux_idx_q;
    hpf_d         = hpf_q;
    batch_len_d   = batch_len_q;
    batch_cnt_d   = batch_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_data_d    = cmd_data_q;
    frame_start_d = 1'b0;
    batch_done_d  = 1'b0;
    aux_src_d     = aux_src_q;
`ifdef RHD_CMD_SCHED_CAL_EN
    cal_pend_d    = cal_pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d       = S_CONV;
          slot_d        = 6'd0;
          hpf_d         = dsp_hpf;
          batch_len_d   = batch_len;
          batch_cnt_d   = 16'd0;
          frame_cnt_d   = 32'd0;
          cmd_valid_d   = 1'b1;
          cmd_data_d    = convert_word(6'd0, dsp_hpf);
          frame_start_d = 1'b1;
          aux_src_d     = 1'b0;
`ifdef RHD_CMD_SCHED_CAL_EN
          cal_pend_d    = 1'b1;
`endif
        end
      end
      S_CONV: begin
        if (accept) begin
          if (slot_q != LAST_CH) begin
            slot_d     = slot_q + 6'd1;
            cmd_data_d = convert_word(slot_q + 6'd1, hpf_q);
          end else begin
            state_d    = S_AUX;
            aux_idx_d  = 3'd0;
            cmd_data_d = aux_word;
            aux_src_d  = aux_word_src;
`ifdef RHD_CMD_SCHED_CAL_EN
            cal_pend_d = 1'b0;
`endif
          end
        end
      end
      S_AUX: begin
        if (accept) begin
          if (aux_idx_q != LAST_AUX) begin
            aux_idx_d  = aux_idx_q + 3'd1;
            cmd_data_d = aux_word;
            aux_src_d  = aux_word_src;
          end else begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            // Use >= so that a batch still closes if batch_len shrank below the running count.
            if ((batch_cnt_q + 16'd1) >= eff_len) begin
              batch_done_d = 1'b1;
              batch_cnt_d  = 16'd0;
            end else begin
              batch_cnt_d  = batch_cnt_q + 16'd1;
            end
            aux_src_d = 1'b0;
            if (run) begin
              state_d       = S_CONV;
              slot_d        = 6'd0;
              hpf_d         = dsp_hpf;
              batch_len_d   = batch_len;
              cmd_data_d    = convert_word(6'd0, dsp_hpf);
              frame_start_d = 1'b1;
            end else begin
              state_d     = S_IDLE;
              cmd_valid_d = 1'b0;
              cmd_data_d  = 16'd0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      slot_q        <= 6'd0;
      aux_idx_q     <= 3'd0;
      hpf_q         <= 1'b0;
      batch_len_q   <= 16'd0;
      batch_cnt_q   <= 16'd0;
      frame_cnt_q   <= 32'd0;
      cmd_valid_q   <= 1'b0;
      cmd_data_q    <= 16'd0;
      frame_start_q <= 1'b0;
      batch_done_q  <= 1'b0;
      aux_src_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      aux_idx_q     <= aux_idx_d;
      hpf_q         <= hpf_d;
      batch_len_q   <= batch_len_d;
      batch_cnt_q   <= batch_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_data_q    <= cmd_data_d;
      frame_start_q <= frame_start_d;
      batch_done_q  <= batch_done_d;
      aux_src_q     <= aux_src_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + LW'(push) - LW'(pop);
    end
  end

`ifdef RHD_CMD_SCHED_CAL_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cal_pend_q <= 1'b0;
    else          cal_pend_q <= cal_pend_d;
  end
`endif

  // Storage only; occupancy and pointers carry the reset state.
  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr_q] <= aux_wr_data;
  end

  assign aux_wr_ready = (count_q != FIFO_FULL);
  assign aux_level    = count_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_data     = cmd_data_q;
  assign frame_start  = frame_start_q;
  assign batch_done   = batch_done_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_count  = frame_cnt_q;

endmodule

// File: tb/tb_rhd_cmd_scheduler.sv
// tb/tb_rhd_cmd_scheduler.sv - directed self-checking bench for rhd_cmd_scheduler
module tb_rhd_cmd_scheduler;

`ifdef RHD_CMD_SCHED_CAL_EN
  localparam bit CAL = 1'b1;
`else
  localparam bit CAL = 1'b0;
`endif
  localparam int FW = 35;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        run = 1'b0;
  logic        dsp_hpf = 1'b0;
  logic [15:0] batch_len = 16'd1;
  logic        aux_wr_valid = 1'b0;
  logic [15:0] aux_wr_data = 16'd0;
  logic        aux_wr_ready;
  logic [4:0]  aux_level;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        cmd_ready = 1'b0;
  logic        frame_start;
  logic        batch_done;
  logic        busy;
  logic [31:0] frame_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          bd_q[$];
  int          fs_q[$];
  int          hold_err;

  rhd_cmd_scheduler dut (
    .aclk(aclk), .aresetn(aresetn), .run(run), .dsp_hpf(dsp_hpf), .batch_len(batch_len),
    .aux_wr_valid(aux_wr_valid), .aux_wr_data(aux_wr_data), .aux_wr_ready(aux_wr_ready),
    .aux_level(aux_level), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .frame_start(frame_start), .batch_done(batch_done), .busy(busy), .frame_count(frame_count)
  );

  always #5 aclk = ~aclk;

  function automatic logic [15:0] conv(input int c, input logic h);
    logic [5:0] cc;
    cc = c[5:0];
    return {2'b00, cc, 7'b0, h};
  endfunction

  // Default-FIFO-empty stream for nframes frames.
  task automatic build_std(input int nframes, input logic h);
    exp_q.delete();
    for (int f = 0; f < nframes; f++) begin
      for (int c = 0; c < 32; c++) exp_q.push_back(conv(c, h));
      for (int a = 0; a < 3; a++)
        exp_q.push_back((CAL && f == 0 && a == 0) ? 16'h5500 : 16'hE800);
    end
  endtask

  task automatic push_word(input logic [15:0] d);
    @(negedge aclk);
    aux_wr_valid = 1'b1;
    aux_wr_data  = d;
    @(negedge aclk);
    aux_wr_valid = 1'b0;
  endtask

  // Starts a run, accepts nframes frames with the given ready duty (percent),
  // drops run during the last frame, and returns at the cycle after the final accept.
  task automatic collect(input int nframes, input int ready_pct);
    int words, total, cyc;
    logic prev_stall;
    logic [15:0] prev_data;
    bit done;
    got_q.delete(); bd_q.delete(); fs_q.delete();
    hold_err = 0; words = 0; total = nframes * FW; prev_stall = 1'b0; prev_data = '0; done = 0;
    @(negedge aclk);
    run = 1'b1;
    cmd_ready = 1'b0;
    for (cyc = 0; cyc < 5000; cyc++) begin
      @(negedge aclk);
      if (batch_done)  bd_q.push_back(words);
      if (frame_start) fs_q.push_back(words);
      if (words == total) begin
        done = 1;
        break;
      end
      if (prev_stall && (cmd_data !== prev_data || cmd_valid !== 1'b1)) hold_err++;
      cmd_ready = ($urandom_range(99) < ready_pct);
      if (cmd_valid && cmd_ready) begin
        got_q.push_back(cmd_data);
        words++;
        if (words == (nframes - 1) * FW + 1) run = 1'b0;
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_data  = cmd_data;
    end
    cmd_ready = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL collect_timeout: words=%0d required=%0d", words, total);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++; if (cmd_valid !== 1'b0)     begin errors++; $display("FAIL rst_cmd_valid: got %b exp 0", cmd_valid); end
    checks++; if (cmd_data !== 16'h0)     begin errors++; $display("FAIL rst_cmd_data: got %h exp 0000", cmd_data); end
    checks++; if (frame_start !== 1'b0)   begin errors++; $display("FAIL rst_frame_start: got %b exp 0", frame_start); end
    checks++; if (batch_done !== 1'b0)    begin errors++; $display("FAIL rst_batch_done: got %b exp 0", batch_done); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if (frame_count !== 32'd0)  begin errors++; $display("FAIL rst_frame_count: got %0d exp 0", frame_count); end
    checks++; if (aux_level !== 5'd0)     begin errors++; $display("FAIL rst_aux_level: got %0d exp 0", aux_level); end
    checks++; if (aux_wr_ready !== 1'b1)  begin errors++; $display("FAIL rst_aux_wr_ready: got %b exp 1", aux_wr_ready); end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_basic();
    dsp_hpf = 1'b0; batch_len = 16'd1;
    build_std(2, 1'b0);
    collect(2, 100);
    checks++; if (got_q.size() != 70) begin errors++; $display("FAIL basic_count: got %0d exp 70", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [15:0] g;
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      checks++;
      if (g !== exp_q[i]) begin errors++; $display("FAIL basic_word[%0d]: got %h exp %h", i, g, exp_q[i]); end
    end
    checks++; if (frame_count !== 32'd2) begin errors++; $display("FAIL basic_frame_count: got %0d exp 2", frame_count); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL basic_busy_after: got %b exp 0", busy); end
    checks++; if (cmd_valid !== 1'b0)    begin errors++; $display("FAIL basic_valid_after: got %b exp 0", cmd_valid); end
    checks++; if (fs_q.size() != 2 || fs_q[0] != 0 || fs_q[1] != FW)
      begin errors++; $display("FAIL basic_frame_start: got n=%0d exp n=2 at words 0,35", fs_q.size()); end
  endtask

  task automatic test_fifo_aux();
    logic [15:0] aux_exp [3];
    push_word(16'h8012);
    push_word(16'hC000);
    checks++; if (aux_level !== 5'd2) begin errors++; $display("FAIL fifo_level_loaded: got %0d exp 2", aux_level); end
    dsp_hpf = 1'b1;
    if (CAL) begin aux_exp[0] = 16'h5500; aux_exp[1] = 16'h8012; aux_exp[2] = 16'hC000; end
    else     begin aux_exp[0] = 16'h8012; aux_exp[1] = 16'hC000; aux_exp[2] = 16'hE800; end
    exp_q.delete();
    for (int c = 0; c < 32; c++) exp_q.push_back(conv(c, 1'b1));
    for (int a = 0; a < 3; a++) exp_q.push_back(aux_exp[a]);
    collect(1, 100);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [15:0] g;
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      checks++;
      if (g !== exp_q[i]) begin errors++; $display("FAIL fifo_word[%0d]: got %h exp %h", i, g, exp_q[i]); end
    end
    checks++; if (aux_level !== 5'd0)    begin errors++; $display("FAIL fifo_level_end: got %0d exp 0", aux_level); end
    checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL fifo_frame_count: got %0d exp 1", frame_count); end
    dsp_hpf = 1'b0;
  endtask

  task automatic test_batch();
    dsp_hpf = 1'b0;
    batch_len = 16'd0;
    collect(6, 100);
    checks++; if (bd_q.size() != 6) begin errors++; $display("FAIL batch0_pulses: got %0d exp 6", bd_q.size()); end
    for (int i = 0; i < bd_q.size() && i < 6; i++) begin
      checks++;
      if (bd_q[i] != FW * (i + 1)) begin errors++; $display("FAIL batch0_at[%0d]: got %0d exp %0d", i, bd_q[i], FW * (i + 1)); end
    end
    batch_len = 16'd3;
    collect(6, 100);
    checks++; if (bd_q.size() != 2) begin errors++; $display("FAIL batch3_pulses: got %0d exp 2", bd_q.size()); end
    else begin
      checks++; if (bd_q[0] != 105) begin errors++; $display("FAIL batch3_first: got %0d exp 105", bd_q[0]); end
      checks++; if (bd_q[1] != 210) begin errors++; $display("FAIL batch3_second: got %0d exp 210", bd_q[1]); end
    end
    checks++; if (frame_count !== 32'd6) begin errors++; $display("FAIL batch_frame_count: got %0d exp 6", frame_count); end
    batch_len = 16'd1;
  endtask

  task automatic test_backpressure();
    dsp_hpf = 1'b0; batch_len = 16'd1;
    build_std(2, 1'b0);
    collect(2, 30);
    checks++; if (got_q.size() != 70) begin errors++; $display("FAIL bp_count: got %0d exp 70", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [15:0] g;
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      checks++;
      if (g !== exp_q[i]) begin errors++; $display("FAIL bp_word[%0d]: got %h exp %h", i, g, exp_q[i]); end
    end
    checks++; if (hold_err != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d violations exp 0", hold_err); end
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 16; i++) push_word(16'h1000 + 16'(i));
    checks++; if (aux_level !== 5'd16)   begin errors++; $display("FAIL full_level: got %0d exp 16", aux_level); end
    checks++; if (aux_wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", aux_wr_ready); end
    push_word(16'h1FFF);
    checks++; if (aux_level !== 5'd16)   begin errors++; $display("FAIL full_drop_level: got %0d exp 16", aux_level); end
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    checks++; if (aux_level !== 5'd0)    begin errors++; $display("FAIL full_reset_level: got %0d exp 0", aux_level); end
    checks++; if (aux_wr_ready !== 1'b1) begin errors++; $display("FAIL full_reset_ready: got %b exp 1", aux_wr_ready); end
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_push_pop();
    bit found;
    for (int i = 0; i < 5; i++) push_word(16'h00A0 + 16'(i));
    checks++; if (aux_level !== 5'd5) begin errors++; $display("FAIL pp_level_loaded: got %0d exp 5", aux_level); end
    @(negedge aclk);
    run = 1'b1; cmd_ready = 1'b1;
    @(negedge aclk);
    run = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cmd_valid && cmd_data == 16'h00A0) begin found = 1; break; end
      @(negedge aclk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL pp_head_seen: got none exp 00a0"); end
    aux_wr_valid = 1'b1; aux_wr_data = 16'h00A5;
    @(negedge aclk);
    aux_wr_valid = 1'b0;
    checks++; if (aux_level !== 5'd5) begin errors++; $display("FAIL pp_push_pop_level: got %0d exp 5", aux_level); end
    found = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (!busy) begin found = 1; break; end
      @(negedge aclk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL pp_stop_timeout: busy still %b exp 0", busy); end
    checks++;
    if (aux_level !== (CAL ? 5'd4 : 5'd3))
      begin errors++; $display("FAIL pp_level_end: got %0d exp %0d", aux_level, CAL ? 4 : 3); end
    checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL pp_frame_count: got %0d exp 1", frame_count); end
    cmd_ready = 1'b0;
    // Clear leftover entries so later streams see an empty FIFO.
    @(negedge aclk); aresetn = 1'b0;
    @(negedge aclk); aresetn = 1'b1;
  endtask

  task automatic test_reset_midframe();
    int words;
    bit reached;
    words = 0; reached = 0;
    @(negedge aclk);
    run = 1'b1; cmd_ready = 1'b1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge aclk);
      if (words == FW + 10) begin reached = 1; break; end
      if (cmd_valid) words++;
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL mid_reach_timeout: words=%0d exp %0d", words, FW + 10); end
    checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL mid_pre_count: got %0d exp 1", frame_count); end
    checks++; if (cmd_data !== conv(10, 1'b0)) begin errors++; $display("FAIL mid_pre_word: got %h exp %h", cmd_data, conv(10, 1'b0)); end
    aresetn = 1'b0; run = 1'b0; cmd_ready = 1'b0;
    #1;
    checks++; if (cmd_valid !== 1'b0)    begin errors++; $display("FAIL mid_rst_valid: got %b exp 0", cmd_valid); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL mid_rst_busy: got %b exp 0", busy); end
    checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL mid_rst_count: got %0d exp 0", frame_count); end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_no_resume: got %b exp 0", cmd_valid); end
    build_std(1, 1'b0);
    collect(1, 100);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [15:0] g;
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      checks++;
      if (g !== exp_q[i]) begin errors++; $display("FAIL mid_word[%0d]: got %h exp %h", i, g, exp_q[i]); end
    end
    checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL mid_post_count: got %0d exp 1", frame_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_aux();
    test_batch();
    test_backpressure();
    test_fifo_full();
    test_push_pop();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
